jt7759_romarb: RTL and testbench
================================

JT7759_ROMARB -- requirements
Module: jt7759_romarb

Interface
REQ-001 The block SHALL have parameter: AW, 17, per-channel ROM byte address width.
REQ-002 The block SHALL have port: clk  in  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: flush  in  1  invalidates both channel hold entries (ROM bank swap).
REQ-005 The block SHALL have port: ch0_cs  in  1  channel 0 request, driven by an ADPCM controller rom_cs.
REQ-006 The block SHALL have port: ch0_addr  in  AW  channel 0 byte address.
REQ-007 The block SHALL have port: ch0_data  out  8  channel 0 read data.
REQ-008 The block SHALL have port: ch0_ok  out  1  ch0_data valid for the current ch0_addr.
REQ-009 The block SHALL have ch1_cs, ch1_addr, ch1_data and ch1_ok identical to REQ-005..008 for channel 1.
REQ-010 The block SHALL have port: rom_cs  out  1  shared ROM request.
REQ-011 The block SHALL have port: rom_addr  out  AW+1  shared ROM address = {granted channel, channel address}.
REQ-012 The block SHALL have port: rom_data  in  8  shared ROM data.
REQ-013 The block SHALL have port: rom_ok  in  1  rom_data valid for rom_addr.

Function
REQ-014 Per channel N, the block SHALL keep a one-entry hold: data_qN[7:0], addr_qN[AW-1:0], validN.
REQ-015 The block SHALL drive chN_ok combinationally = chN_cs & validN & (chN_addr == addr_qN), and chN_data = data_qN at all times.
REQ-016 pendN SHALL be defined as chN_cs & ~(validN & chN_addr == addr_qN).
REQ-017 The FSM SHALL have states IDLE, SETTLE and WAIT, encoded one-hot.
REQ-018 In IDLE with only one pendN set, the block SHALL grant N; with both set, it SHALL grant the channel not equal to last_grant (round robin).
REQ-019 On a grant at cycle t, at t+1 the block SHALL set rom_cs=1, rom_addr={N, chN_addr sampled at t} and gnt=N, and SHALL go to SETTLE.
REQ-020 SETTLE SHALL last exactly one cycle, ignore rom_ok (stale from the previous address) and go to WAIT.
REQ-021 In WAIT, the block SHALL hold rom_cs and rom_addr stable until a cycle u with rom_ok=1.
REQ-022 At u+1 the block SHALL set data_q[gnt]=rom_data(u), addr_q[gnt]=rom_addr[AW-1:0], valid[gnt]=1, rom_cs=0, last_grant=gnt, st=IDLE.
REQ-023 chN_ok SHALL therefore rise no earlier than u+1; minimum request-to-ok latency SHALL be 3 cycles (t to t+3 with rom_ok constant high).
REQ-024 rom_cs SHALL be low for at least one cycle between consecutive accesses; the next grant SHALL be evaluated in the IDLE cycle u+1.
REQ-025 If chN_cs falls or chN_addr changes while N is granted, the block SHALL complete the access and store the result for the latched address; a mismatch then SHALL raise pendN again.
REQ-026 The block SHALL never grant a channel whose pendN is 0; with no pending channel, IDLE SHALL persist with rom_cs=0.
REQ-027 flush SHALL clear valid0 and valid1 on the next edge.
REQ-028 When flush is high during SETTLE or WAIT, the block SHALL set a drop flag, and the completing capture SHALL store data but leave valid[gnt]=0.
REQ-029 When flush coincides with the completion edge u, valid[gnt] SHALL end at 0.
REQ-030 The drop flag SHALL clear on return to IDLE.
REQ-031 Hold entries SHALL persist across chN_cs low periods, so a repeated address after a cs pulse SHALL be served without a ROM access.

Reset
REQ-032 While rst=1, the block SHALL set st=IDLE, rom_cs=0, rom_addr=0, data_q0/1=0, addr_q0/1=0, valid0/1=0, gnt=0, last_grant=1 (channel 0 wins the first tie) and drop=0.
REQ-033 Reset asserted mid-access SHALL abort it: rom_cs=0 on the next edge and no hold entry written.

Verification
REQ-034 The bench SHALL cover single request: ch0_cs=1, addr=0x00123, rom_ok delayed by 4 cycles -> rom_addr=0x00123, rom_cs for 1+1+4 cycles, ch0_ok=1 with the ROM byte, then rom_cs=0.
REQ-035 The bench SHALL cover tie after reset: both cs rise together at 0x00010/0x00020 -> ch0 served first (rom_addr=0x00010), then ch1 (0x20020), rom_cs low one cycle between.
REQ-036 The bench SHALL cover fairness: both channels request a new address after every ok for 20 accesses -> grants strictly alternate.
REQ-037 The bench SHALL cover hit: ch1 re-requests the same address after a cs low pulse -> ch1_ok high in the same cycle as cs, no rom_cs.
REQ-038 The bench SHALL cover flush: flush pulses during WAIT for ch0 -> after completion ch0_ok stays 0, and a second access to the same address is issued.
REQ-039 The bench SHALL cover reset in WAIT: rst pulses -> rom_cs=0 next cycle, both ok low, and the first subsequent tie goes to ch0.

Source files
------------

// File: rtl/jt7759_romarb.sv
`timescale 1ns/1ps
// Shares one ADPCM sample ROM between two channels, each with a one-byte address/data hold.
// Latency: a hold hit is combinational; a miss takes >= 3 cycles (grant, settle, capture).
// Backpressure: a channel sees chN_ok low until its byte arrives; rom_cs stays up until rom_ok.
module jt7759_romarb #(
   parameter int AW = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          ch0_cs,
   input  logic [AW-1:0] ch0_addr,
   output logic [7:0]    ch0_data,
   output logic          ch0_ok,
   input  logic          ch1_cs,
   input  logic [AW-1:0] ch1_addr,
   output logic [7:0]    ch1_data,
   output logic          ch1_ok,
   output logic          rom_cs,
   output logic [AW:0]   rom_addr,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok
);

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      SETTLE = 3'b010,
      WAIT   = 3'b100
   } st_t;

   st_t           st_q, st_d;
   logic          rom_cs_q, rom_cs_d;
   logic [AW:0]   rom_addr_q, rom_addr_d;
   logic          gnt_q, gnt_d;
   logic          last_q, last_d;
   logic          drop_q, drop_d;
   logic [7:0]    data0_q, data0_d, data1_q, data1_d;
   logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic          valid0_q, valid0_d, valid1_q, valid1_d;

   logic          hit0, hit1, pend0, pend1, sel;

   // A channel is served from its hold entry when the stored address matches.
   assign hit0  = valid0_q && (ch0_addr == addr0_q);
   assign hit1  = valid1_q && (ch1_addr == addr1_q);
   assign pend0 = ch0_cs && !hit0;
   assign pend1 = ch1_cs && !hit1;

   assign ch0_ok   = ch0_cs && hit0;
   assign ch1_ok   = ch1_cs && hit1;
   assign ch0_data = data0_q;
   assign ch1_data = data1_q;
   assign rom_cs   = rom_cs_q;
   assign rom_addr = rom_addr_q;

   // Next-state: round-robin grant in IDLE, one dead cycle in SETTLE, capture in WAIT.
   always_comb begin
      st_d       = st_q;
      rom_cs_d   = rom_cs_q;
      rom_addr_d = rom_addr_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      drop_d     = drop_q;
      data0_d    = data0_q;
      data1_d    = data1_q;
      addr0_d    = addr0_q;
      addr1_d    = addr1_q;
      valid0_d   = valid0_q;
      valid1_d   = valid1_q;
      sel        = 1'b0;

      // A bank swap invalidates both holds; a capture below may still override
      // its own entry, but only ever to 0 while flush is high.
      if (flush) begin
         valid0_d = 1'b0;
         valid1_d = 1'b0;
      end

      case (st_q)
         IDLE: begin
            if (pend0 || pend1) begin
               sel        = (pend0 && pend1) ? ~last_q : pend1;
               rom_cs_d   = 1'b1;
               rom_addr_d = {sel, (sel ? ch1_addr : ch0_addr)};
               gnt_d      = sel;
               drop_d     = 1'b0;
               st_d       = SETTLE;
            end
         end
         SETTLE: begin
            // rom_ok here still refers to the previous address, so it is ignored.
            if (flush) drop_d = 1'b1;
            st_d = WAIT;
         end
         WAIT: begin
            if (flush) drop_d = 1'b1;
            if (rom_ok) begin
               // Store against the latched address, not the live one, so a
               // channel that moved on simply misses again afterwards.
               if (gnt_q) begin
                  data1_d  = rom_data;
                  addr1_d  = rom_addr_q[AW-1:0];
                  valid1_d = ~(drop_q | flush);
               end else begin
                  data0_d  = rom_data;
                  addr0_d  = rom_addr_q[AW-1:0];
                  valid0_d = ~(drop_q | flush);
               end
               rom_cs_d = 1'b0;
               last_d   = gnt_q;
               drop_d   = 1'b0;
               st_d     = IDLE;
            end
         end
         default: begin
            rom_cs_d = 1'b0;
            drop_d   = 1'b0;
            st_d     = IDLE;
         end
      endcase
   end

   // State registers; reset aborts any access and makes channel 0 win the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= IDLE;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;
         drop_q     <= 1'b0;
         data0_q    <= '0;
         data1_q    <= '0;
         addr0_q    <= '0;
         addr1_q    <= '0;
         valid0_q   <= 1'b0;
         valid1_q   <= 1'b0;
      end else begin
         st_q       <= st_d;
         rom_cs_q   <= rom_cs_d;
         rom_addr_q <= rom_addr_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         drop_q     <= drop_d;
         data0_q    <= data0_d;
         data1_q    <= data1_d;
         addr0_q    <= addr0_d;
         addr1_q    <= addr1_d;
         valid0_q   <= valid0_d;
         valid1_q   <= valid1_d;
      end
   end

endmodule

// File: tb/tb_jt7759_romarb.sv
`timescale 1ns/1ps
// Bench for jt7759_romarb: directed tables, hand sequences and random traffic.
// Latency: outputs sampled 2 time units after each rising edge.
// Backpressure: the ROM model stretches rom_ok by a per-access delay.
module tb_jt7759_romarb;

   localparam int AW = 17;

   logic          clk;
   logic          rst, flush;
   logic          ch0_cs, ch1_cs;
   logic [AW-1:0] ch0_addr, ch1_addr;
   logic [7:0]    ch0_data, ch1_data;
   logic          ch0_ok, ch1_ok;
   logic          rom_cs;
   logic [AW:0]   rom_addr;
   logic [7:0]    rom_data;
   logic          rom_ok;

   jt7759_romarb #(.AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .ch0_cs   (ch0_cs),
      .ch0_addr (ch0_addr),
      .ch0_data (ch0_data),
      .ch0_ok   (ch0_ok),
      .ch1_cs   (ch1_cs),
      .ch1_addr (ch1_addr),
      .ch1_data (ch1_data),
      .ch1_ok   (ch1_ok),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model (transaction level) ----------------
   logic          m_busy;     // an access is outstanding on the ROM
   int            m_age;      // cycles the ROM has seen this request (1 = settle cycle)
   logic          m_gnt;
   logic [AW-1:0] m_addr;
   logic [AW:0]   m_raddr;
   int            m_dly;      // extra cycles before the ROM answers
   logic          m_drop;
   logic          m_last;
   logic          m_v  [2];
   logic [AW-1:0] m_ha [2];
   logic [7:0]    m_hd [2];
   int            dly_cur;

   function automatic logic [7:0] rom_byte(input logic [AW:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ {4{a[17:16]}} ^ 8'h3C;
   endfunction

   function automatic logic exp_ok(input int n, input logic cs, input logic [AW-1:0] a);
      return cs && m_v[n] && (a == m_ha[n]);
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_age = 0; m_gnt = 1'b0; m_addr = '0; m_raddr = '0;
      m_dly = 0; m_drop = 1'b0; m_last = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_v[i] = 1'b0; m_ha[i] = '0; m_hd[i] = '0;
      end
   endtask

   // ROM answers with stale data during the first cycle of a request and
   // with the real byte once the configured delay has elapsed.
   task automatic drive_rom();
      if (m_busy) begin
         if (m_age == 1) begin
            rom_ok   = 1'b1;
            rom_data = ~rom_byte(m_raddr);
         end else begin
            rom_ok   = (m_age >= m_dly + 2);
            rom_data = rom_ok ? rom_byte(m_raddr) : ~rom_byte(m_raddr);
         end
      end else begin
         rom_ok   = 1'($urandom_range(0, 1));
         rom_data = 8'($urandom);
      end
   endtask

   task automatic model_step();
      logic p0, p1, g, done;
      p0 = ch0_cs && !(m_v[0] && ch0_addr == m_ha[0]);
      p1 = ch1_cs && !(m_v[1] && ch1_addr == m_ha[1]);
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         if (flush) begin m_v[0] = 1'b0; m_v[1] = 1'b0; end
         if (p0 || p1) begin
            g       = (p0 && p1) ? ~m_last : p1;
            m_busy  = 1'b1;
            m_age   = 1;
            m_gnt   = g;
            m_addr  = g ? ch1_addr : ch0_addr;
            m_raddr = {g, m_addr};
            m_dly   = dly_cur;
            m_drop  = 1'b0;
         end
      end else begin
         done = (m_age >= 2) && rom_ok;
         if (flush) begin m_v[0] = 1'b0; m_v[1] = 1'b0; m_drop = 1'b1; end
         if (done) begin
            m_hd[m_gnt] = rom_data;
            m_ha[m_gnt] = m_addr;
            m_v[m_gnt]  = !m_drop;
            m_last      = m_gnt;
            m_busy      = 1'b0;
            m_drop      = 1'b0;
         end else begin
            m_age = m_age + 1;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("rom_cs",   32'(rom_cs),   32'(m_busy));
      chk("rom_addr", 32'(rom_addr), 32'(m_raddr));
      chk("ch0_ok",   32'(ch0_ok),   32'(exp_ok(0, ch0_cs, ch0_addr)));
      chk("ch1_ok",   32'(ch1_ok),   32'(exp_ok(1, ch1_cs, ch1_addr)));
      chk("ch0_data", 32'(ch0_data), 32'(m_hd[0]));
      chk("ch1_data", 32'(ch1_data), 32'(m_hd[1]));
   endtask

   // Inputs for the cycle are already applied when half() is called.
   task automatic half();
      drive_rom();
      #1;
      check_model();
   endtask

   task automatic adv();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      half();
      adv();
   endtask

   // ---------------- directed cycle table ----------------
   typedef struct {
      logic          r, f, c0;
      logic [AW-1:0] a0;
      logic          c1;
      logic [AW-1:0] a1;
      int            dly;
      logic          e_cs;
      logic [AW:0]   e_addr;
      logic          e_ok0, e_ok1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic f, input logic c0,
                               input logic [AW-1:0] a0, input logic c1,
                               input logic [AW-1:0] a1, input int d,
                               input logic ecs, input logic [AW:0] ea,
                               input logic eo0, input logic eo1);
      vec_t v;
      v.r = r; v.f = f; v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1; v.dly = d;
      v.e_cs = ecs; v.e_addr = ea; v.e_ok0 = eo0; v.e_ok1 = eo1;
      return v;
   endfunction

   logic [AW-1:0] apool [4];
   logic [AW-1:0] fa0, fa1;
   logic          prev_cs, bump0, bump1, got;
   int            ng, hi, lat;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      // tie after reset, then ch1 served
      tbl.push_back(mk(0,0,1,17'h10,1,17'h20,0, 0,18'h00000,0,0));
      tbl.push_back(mk(0,0,1,17'h10,1,17'h20,0, 1,18'h00010,0,0));
      tbl.push_back(mk(0,0,1,17'h10,1,17'h20,0, 1,18'h00010,0,0));
      tbl.push_back(mk(0,0,1,17'h10,1,17'h20,0, 0,18'h00010,1,0));
      tbl.push_back(mk(0,0,1,17'h10,1,17'h20,0, 1,18'h20020,1,0));
      tbl.push_back(mk(0,0,1,17'h10,1,17'h20,0, 1,18'h20020,1,0));
      tbl.push_back(mk(0,0,1,17'h10,1,17'h20,0, 0,18'h20020,1,1));
      // ch1 cs pulse low, same address is a hit with no ROM access
      tbl.push_back(mk(0,0,0,17'h10,0,17'h20,0, 0,18'h20020,0,0));
      tbl.push_back(mk(0,0,0,17'h10,1,17'h20,0, 0,18'h20020,0,1));
      tbl.push_back(mk(0,0,0,17'h10,1,17'h20,0, 0,18'h20020,0,1));
      // flush during WAIT of ch0: result dropped, access repeated
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 0,18'h20020,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,1,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 0,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 1,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h30,0,17'h20,2, 0,18'h00030,1,0));
      // flush on the completion edge
      tbl.push_back(mk(0,0,1,17'h40,0,17'h20,0, 0,18'h00030,0,0));
      tbl.push_back(mk(0,0,1,17'h40,0,17'h20,0, 1,18'h00040,0,0));
      tbl.push_back(mk(0,1,1,17'h40,0,17'h20,0, 1,18'h00040,0,0));
      tbl.push_back(mk(0,0,1,17'h40,0,17'h20,0, 0,18'h00040,0,0));
      tbl.push_back(mk(0,0,1,17'h40,0,17'h20,0, 1,18'h00040,0,0));
      tbl.push_back(mk(0,0,1,17'h40,0,17'h20,0, 1,18'h00040,0,0));
      tbl.push_back(mk(0,0,1,17'h40,0,17'h20,0, 0,18'h00040,1,0));
      // reset during WAIT of ch1, then the tie goes to ch0
      tbl.push_back(mk(0,0,1,17'h40,1,17'h50,3, 0,18'h00040,1,0));
      tbl.push_back(mk(0,0,1,17'h40,1,17'h50,3, 1,18'h20050,1,0));
      tbl.push_back(mk(1,0,1,17'h40,1,17'h50,3, 1,18'h20050,1,0));
      tbl.push_back(mk(0,0,1,17'h40,1,17'h50,3, 0,18'h00000,0,0));
      tbl.push_back(mk(0,0,1,17'h40,1,17'h50,3, 1,18'h00040,0,0));

      apool[0] = 17'h00000; apool[1] = 17'h00001;
      apool[2] = 17'h1FFFF; apool[3] = 17'h0ABCD;

      rst = 1'b1; flush = 1'b0;
      ch0_cs = 1'b0; ch1_cs = 1'b0; ch0_addr = '0; ch1_addr = '0;
      rom_ok = 1'b0; rom_data = 8'h00; dly_cur = 0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();

      // reset state
      half();
      chk("rst_rom_cs",   32'(rom_cs),   32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_ok0",      32'(ch0_ok),   32'd0);
      chk("rst_ok1",      32'(ch1_ok),   32'd0);
      chk("rst_data0",    32'(ch0_data), 32'd0);
      chk("rst_data1",    32'(ch1_data), 32'd0);
      adv();
      rst = 1'b0;

      // single request with a 4-cycle ROM delay
      ch0_cs = 1'b1; ch0_addr = 17'h00123; dly_cur = 4;
      cyc();
      hi = 0; lat = 0; got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         half();
         if (k == 1) chk("single_addr", 32'(rom_addr), 32'h00123);
         if (rom_cs) hi++;
         if (ch0_ok) begin
            got = 1'b1;
            lat = k;
            chk("single_data", 32'(ch0_data), 32'(rom_byte(18'h00123)));
            chk("single_cs_after", 32'(rom_cs), 32'd0);
         end
         adv();
      end
      chk("single_latency", 32'(lat), 32'd7);
      chk("single_cs_cycles", 32'(hi), 32'd6);
      ch0_cs = 1'b0;
      cyc();

      // cycle table, from a fresh reset
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      foreach (tbl[i]) begin
         rst = tbl[i].r; flush = tbl[i].f;
         ch0_cs = tbl[i].c0; ch0_addr = tbl[i].a0;
         ch1_cs = tbl[i].c1; ch1_addr = tbl[i].a1;
         dly_cur = tbl[i].dly;
         half();
         chk($sformatf("tbl%0d_rom_cs", i),   32'(rom_cs),   32'(tbl[i].e_cs));
         chk($sformatf("tbl%0d_rom_addr", i), 32'(rom_addr), 32'(tbl[i].e_addr));
         chk($sformatf("tbl%0d_ok0", i),      32'(ch0_ok),   32'(tbl[i].e_ok0));
         chk($sformatf("tbl%0d_ok1", i),      32'(ch1_ok),   32'(tbl[i].e_ok1));
         adv();
      end
      rst = 1'b0; flush = 1'b0;

      // fairness: both channels always want a fresh address
      fa0 = 17'h00100; fa1 = 17'h00200;
      ch0_cs = 1'b1; ch1_cs = 1'b1; ch0_addr = fa0; ch1_addr = fa1; dly_cur = 1;
      prev_cs = 1'b1; ng = 0;
      for (int k = 0; k < 400 && ng < 20; k++) begin
         half();
         if (rom_cs && !prev_cs) begin
            chk($sformatf("fair_gnt%0d", ng), 32'(rom_addr[AW]), ((ng % 2) == 0) ? 32'd1 : 32'd0);
            ng++;
         end
         prev_cs = rom_cs;
         bump0 = exp_ok(0, ch0_cs, ch0_addr);
         bump1 = exp_ok(1, ch1_cs, ch1_addr);
         adv();
         if (bump0) begin fa0 = fa0 + 17'd1; ch0_addr = fa0; end
         if (bump1) begin fa1 = fa1 + 17'd1; ch1_addr = fa1; end
      end
      chk("fair_count", 32'(ng), 32'd20);

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0) begin
            ch0_cs   = 1'($urandom_range(0, 1));
            ch0_addr = apool[$urandom_range(0, 3)];
         end
         if ($urandom_range(0, 3) == 0) begin
            ch1_cs   = 1'($urandom_range(0, 1));
            ch1_addr = apool[$urandom_range(0, 3)];
         end
         dly_cur = $urandom_range(0, 3);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
